// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic note scheduler. Shares NUM_VOICES voice instances among a stream
// of note events. Each accepted event is matched against the voices over one
// scan pass (one voice per cycle), then committed in a single cycle:
// note-off releases a matching voice, note-on takes the lowest free voice or,
// when every voice is busy, steals the oldest one. A stolen voice keeps its
// gate low for GATE_GAP_CYCLES so its envelope can release before the new
// note is loaded.
//
// Ports
//   main_clk    system clock
//   rst         asynchronous reset, active-high
//   ev_valid    event offered
//   ev_ready    event accepted when ev_valid && ev_ready (high only in IDLE)
//   ev_note_on  1 = note-on, 0 = note-off
//   ev_note     note number, used as the match key
//   ev_freq     tone frequency loaded on note-on
//   all_off     panic: clears every gate and drops any in-flight event
//   voice_gate  gate per voice
//   voice_freq  tone_freq per voice, voice i at [i*FREQ_BITS +: FREQ_BITS]
//   voice_note  note held per voice, voice i at [i*7 +: 7]
//   stolen      one-cycle pulse when a steal commits
// -----------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES      = 4,
    parameter int FREQ_BITS       = 16,
    parameter int AGE_BITS        = 4,
    parameter int GATE_GAP_CYCLES = 1024
) (
    input  logic                            main_clk,
    input  logic                            rst,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_note_on,
    input  logic [6:0]                      ev_note,
    input  logic [FREQ_BITS-1:0]            ev_freq,
    input  logic                            all_off,
    output logic [NUM_VOICES-1:0]           voice_gate,
    output logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq,
    output logic [NUM_VOICES*7-1:0]         voice_note,
    output logic                            stolen
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int GAP_W = (GATE_GAP_CYCLES > 1) ? $clog2(GATE_GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, GAP} state_t;
    typedef logic [IDX_W-1:0] idx_t;

    state_t state, state_next;

    // Registered event
    logic                 ev_on_q;
    logic [6:0]           ev_note_q;
    logic [FREQ_BITS-1:0] ev_freq_q;

    // Scan bookkeeping
    idx_t                 scan_idx;
    logic                 match_found, free_found, old_found;
    idx_t                 match_idx, free_idx, old_idx;
    logic [AGE_BITS-1:0]  old_age;
    logic [GAP_W-1:0]     gap_cnt;

    // Per-voice storage
    logic [FREQ_BITS-1:0] freq_r [NUM_VOICES];
    logic [6:0]           note_r [NUM_VOICES];
    logic [AGE_BITS-1:0]  age_r  [NUM_VOICES];

    logic                 scan_last, gap_last, steal;
    idx_t                 alloc_idx;
    logic                 cur_gate;
    logic [6:0]           cur_note;
    logic [AGE_BITS-1:0]  cur_age;

    assign ev_ready  = (state == IDLE);
    assign scan_last = (scan_idx == idx_t'(NUM_VOICES - 1));
    assign gap_last  = (gap_cnt == GAP_W'(GATE_GAP_CYCLES - 1));
    // A note-on that neither matches nor finds a free voice must steal.
    assign steal     = ev_on_q && !match_found && !free_found;
    assign alloc_idx = free_found ? free_idx : old_idx;

    assign cur_gate  = voice_gate[scan_idx];
    assign cur_note  = note_r[scan_idx];
    assign cur_age   = age_r[scan_idx];

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_freq[g*FREQ_BITS +: FREQ_BITS] = freq_r[g];
        assign voice_note[g*7 +: 7]                 = note_r[g];
    end

    // NOTE: state and storage use nonblocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (ev_valid)  state_next = SCAN;
            SCAN:    if (scan_last) state_next = COMMIT;
            COMMIT:  state_next = steal ? GAP : IDLE;
            GAP:     if (gap_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (all_off) state_next = IDLE;
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            ev_freq_q   <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            gap_cnt     <= '0;
            stolen      <= 1'b0;
            voice_gate  <= '0;
            // NOTE: voice storage is reset explicitly because freq/note are
            // visible on the outputs and must come up as zero.
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_r[i] <= '0;
                note_r[i] <= '0;
                age_r[i]  <= '0;
            end
        end else begin
            stolen <= 1'b0;
            if (all_off) begin
                // Panic wins over everything; freq/note/age are left alone.
                voice_gate <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ev_valid) begin
                            ev_on_q     <= ev_note_on;
                            ev_note_q   <= ev_note;
                            ev_freq_q   <= ev_freq;
                            scan_idx    <= '0;
                            match_found <= 1'b0;
                            free_found  <= 1'b0;
                            old_found   <= 1'b0;
                        end
                    end
                    SCAN: begin
                        if (cur_gate && cur_note == ev_note_q && !match_found) begin
                            match_found <= 1'b1;
                            match_idx   <= scan_idx;
                        end
                        if (!cur_gate && !free_found) begin
                            free_found <= 1'b1;
                            free_idx   <= scan_idx;
                        end
                        // Strictly greater keeps the lowest index on ties.
                        if (cur_gate && (!old_found || cur_age > old_age)) begin
                            old_found <= 1'b1;
                            old_idx   <= scan_idx;
                            old_age   <= cur_age;
                        end
                        scan_idx <= scan_idx + 1'b1;
                    end
                    COMMIT: begin
                        if (!ev_on_q) begin
                            if (match_found) voice_gate[match_idx] <= 1'b0;
                        end else if (!match_found) begin
                            if (free_found) begin
                                voice_gate[free_idx] <= 1'b1;
                                freq_r[free_idx]     <= ev_freq_q;
                                note_r[free_idx]     <= ev_note_q;
                            end else begin
                                voice_gate[old_idx] <= 1'b0;
                                stolen              <= 1'b1;
                                gap_cnt             <= '0;
                            end
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (idx_t'(i) == alloc_idx)
                                    age_r[i] <= '0;
                                else if (age_r[i] != '1)
                                    age_r[i] <= age_r[i] + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_last) begin
                            voice_gate[old_idx] <= 1'b1;
                            freq_r[old_idx]     <= ev_freq_q;
                            note_r[old_idx]     <= ev_note_q;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
